joy_db15_tx: RTL

- Responder (device end) of the DB15 serial joystick link whose host end generates JOY_LOAD/JOY_CLK and samples JOY_DATA.
- Emulates the adapter's 74HC165 shift-register chain: parallel-captures two 16-bit button words on load, shifts them out one bit per JOY_CLK rising edge.
- Used to drive a DB15 host from on-chip joystick state (loopback bench, link-cable bridging), clocked from CLK_JOY (40-50 MHz).

---
 rtl/joy_db15_tx.sv | 88 ++++++++
 1 files changed

// File: rtl/joy_db15_tx.sv
// Device end of the DB15 serial joystick link: emulates the 74HC165 chain that
// captures two button words while JOY_LOAD is low and shifts them out on JOY_CLK.
module joy_db15_tx #(
    parameter int NBITS       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    input  logic        joy_load,
    input  logic        joy_clk,
    output logic        joy_data,
    output logic        frame_done,
    output logic [5:0]  bit_count
);

    localparam logic [5:0] CNT_LAST = 6'(NBITS - 1);
    localparam logic [5:0] CNT_FULL = 6'(NBITS);

    logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q,  clk_sync_d;
    logic                   clk_dly_q,   clk_dly_d;
    logic [NBITS-1:0]       sreg_q,      sreg_d;
    logic [5:0]             cnt_q,       cnt_d;
    logic                   done_q,      done_d;
    logic                   data_q,      data_d;

    logic        load_s;
    logic        clk_rise;
    logic [31:0] frame_all;

    // Synchronizers and the edge-detect delay flop; all reset high so that
    // the release of reset never looks like a rising edge.
    always_comb begin
        load_sync_d = {load_sync_q[SYNC_STAGES-2:0], joy_load};
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
        clk_dly_d   = clk_sync_q[SYNC_STAGES-1];
        load_s      = load_sync_q[SYNC_STAGES-1];
        clk_rise    = clk_sync_q[SYNC_STAGES-1] & ~clk_dly_q;
    end

    // Buttons are active high on chip, active low on the wire.
    assign frame_all = ~{joystick2, joystick1};

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (!load_s) begin
            // Load dominates: a clock edge coinciding with a low load is dropped.
            sreg_d = frame_all[NBITS-1:0];
            cnt_d  = '0;
        end else if (clk_rise) begin
            sreg_d = {1'b1, sreg_q[NBITS-1:1]};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 6'd1;
            end
            done_d = (cnt_q == CNT_LAST);
        end
        data_d = sreg_q[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_sync_q <= '1;
            clk_sync_q  <= '1;
            clk_dly_q   <= 1'b1;
            sreg_q      <= '1;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            data_q      <= 1'b1;
        end else begin
            load_sync_q <= load_sync_d;
            clk_sync_q  <= clk_sync_d;
            clk_dly_q   <= clk_dly_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            data_q      <= data_d;
        end
    end

    assign joy_data   = data_q;
    assign frame_done = done_q;
    assign bit_count  = cnt_q;

endmodule
